// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath.
//   BCD_DIGIT_W     : bits per packed BCD digit
//   BCD_RADIX       : decimal radix, used for borrow correction and the digit check
//   bcd_sub_state_t : control states of the digit-serial subtractor
//   is_bcd_digit()  : 1 when a 4-bit code is a legal decimal digit (0..9)
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_sub_state_t;

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return d < BCD_DIGIT_W'(BCD_RADIX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor slice: d = a_d - b_d - bin with decimal borrow.
// Ports:
//   a_d  [3:0] in  : minuend digit
//   b_d  [3:0] in  : subtrahend digit
//   bin        in  : borrow in
//   d    [3:0] out : difference digit
//   bout       out : borrow out
// Digits above 9 go through the same arithmetic without correction.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   bin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   bout
);

  // 5-bit two's-complement intermediate; bit 4 set means the digit went negative.
  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t = {1'b0, a_d} - {1'b0, b_d} - {{BCD_DIGIT_W{1'b0}}, bin};
    if (t[BCD_DIGIT_W]) begin
      // adding the radix modulo 16 gives t + 10 for any t in -16..-1
      d    = t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX);
      bout = 1'b1;
    end else begin
      d    = t[BCD_DIGIT_W-1:0];
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial multi-digit BCD subtractor: diff = a - b - bin, one digit per
// clock, least-significant digit first, with a start/busy/done handshake.
// A final borrow (bout=1) marks a negative result held in ten's-complement form.
// Ports:
//   clk, rst (async, active high)
//   start          : request, accepted in IDLE or DONE
//   a, b [4*DIGITS]: packed BCD operands, digit 0 in [3:0]
//   bin            : borrow in, sampled with start
//   diff [4*DIGITS]: packed BCD result, held until next accepted start
//   bout           : final borrow out
//   busy, done     : busy while digits are processed; done pulses one cycle
//   err            : invalid-digit flag
// Optional build macro BCD_SUB_DIGIT_CHECK_EN: when defined, err flags any
// operand digit above 9 at the accepted start; otherwise err is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | subtracting digit idx each edge
// DONE  | result valid, done pulse; a new start is accepted here
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
  output logic                          bout,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_sub_state_t         state;
  logic [W-1:0]           a_q;
  logic [W-1:0]           b_q;
  logic [IDX_W-1:0]       idx;
  logic                   borrow;

  logic [BCD_DIGIT_W-1:0] a_dig;
  logic [BCD_DIGIT_W-1:0] b_dig;
  logic [BCD_DIGIT_W-1:0] d_dig;
  logic                   borrow_nxt;

  assign a_dig = a_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign b_dig = b_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_digit_sub u_digit (
    .a_d  (a_dig),
    .b_d  (b_dig),
    .bin  (borrow),
    .d    (d_dig),
    .bout (borrow_nxt)
  );

`ifdef BCD_SUB_DIGIT_CHECK_EN
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !is_bcd_digit(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        bad_digit = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            busy   <= 1'b1;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err    <= bad_digit;
`endif
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          diff[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= d_dig;
          borrow <= borrow_nxt;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            bout  <= borrow_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: the driver pushes the expected result
// (from a decimal-integer reference model) when an operation is accepted, and
// a monitor pops and compares whenever done is seen.
module tb_bcd_sub_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
    logic         chk_diff;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;
  logic         err;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: treat operands as decimal integers, subtract, wrap modulo 10^DIGITS.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t e;
    int va = 0, vb = 0, p = 1, r;
    logic [3:0] da, db;
    e.err = 1'b0;
    e.chk_diff = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      da = av[i*4 +: 4];
      db = bv[i*4 +: 4];
      if (da > 9 || db > 9) e.chk_diff = 1'b0;
      va += int'(da) * p;
      vb += int'(db) * p;
      p *= 10;
    end
`ifdef BCD_SUB_DIGIT_CHECK_EN
    e.err = !e.chk_diff;
`endif
    r = va - vb - int'(bi);
    e.bout = (r < 0);
    if (r < 0) r += p;
    e.diff = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.diff[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Called at a negedge when the DUT is idle or in DONE; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input bit push);
    exp_t e;
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    e = model(av, bv, bi);
    e.cyc = cyc + DIGITS;
    if (push) sb.push_back(e);
    check("busy_after_start", busy, 1);
    check("err_with_busy", err, e.err);
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle with start dropped.
  task automatic wait_done(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int k = 0; k < 4 * DIGITS; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
    end
    if (!seen) check("done_timeout", done, 1);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_diff) begin
          check("diff", diff, mon_e.diff);
          check("bout", bout, mon_e.bout);
        end
        check("err", err, mon_e.err);
        check("done_cycle", cyc, mon_e.cyc);
        check("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    int nb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h0042, 16'h0017, 1'b0, 1);
    wait_done(nb);
    check("busy_cycles", nb, DIGITS);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    issue(16'h0017, 16'h0042, 1'b0, 1);
    wait_done(nb);
    @(negedge clk);

    issue(16'h1000, 16'h0001, 1'b0, 1);
    wait_done(nb);
    @(negedge clk);
    issue(16'h0000, 16'h0000, 1'b1, 1);
    wait_done(nb);
    @(negedge clk);

    // start held high with other operands while busy must not disturb the result
    issue(16'h1234, 16'h0567, 1'b0, 1);
    a = 16'h9999; b = 16'h1111; bin = 1'b1; start = 1'b1;
    wait_done(nb);
    // accepted in the DONE cycle: back-to-back
    issue(16'h0500, 16'h0250, 1'b1, 1);
    wait_done(nb);
    @(negedge clk);

    // abort mid-operation
    issue(16'h0888, 16'h0111, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0005, 16'h0003, 1'b0, 1);
    wait_done(nb);
    @(negedge clk);

    // invalid digit: result not checked, err depends on build
    issue(16'h00A0, 16'h0000, 1'b0, 1);
    wait_done(nb);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1);
      wait_done(nb);
      check("rand_busy_cycles", nb, DIGITS);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
